// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared RV32I opcodes, FSM states and control encodings
//
// Purpose: single source of opcode constants and control-field encodings for
//          the RV32I control logic (single-cycle decoder and multi-cycle FSM).
// Ports:   none (package).
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_HALT   = 7'b1111111;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALTED  = 3'd5,
    S_ILLEGAL = 3'd6,
    S_ERROR   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_BR  = 2'b01,
    ALU_R   = 2'b10,
    ALU_I   = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    M2R_ALU = 2'b00,
    M2R_MEM = 2'b01,
    M2R_PC4 = 2'b10,
    M2R_IMM = 2'b11
  } mem_to_reg_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_JALR   = 2'b10
  } pc_src_e;

  // HALT is handled separately by the caller; this only covers executable opcodes.
  function automatic logic op_legal(input logic [6:0] op, input logic en_upper_imm);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_R_TYPE, OP_I_TYPE, OP_LW, OP_SW,
      OP_BRANCH, OP_JAL, OP_JALR:  ok = 1'b1;
      OP_LUI, OP_AUIPC:            ok = en_upper_imm;
      default:                     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ctrl_mem_timer.sv
// rtl/ctrl_mem_timer.sv - memory handshake wait counter with timeout flag
//
// Purpose: counts consecutive cycles a request waits without mem_ready.
// Ports:   clk, rst_n (sync active-low), waiting (req & ~ready this cycle),
//          clear (ready seen or FSM state change), expire (this wait cycle
//          is the MEM_TIMEOUT-th one; the FSM leaves for ERROR at the edge).
module ctrl_mem_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic clear,
  output logic expire
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (waiting) begin
      count <= count + 1'b1;
    end
  end

  // Only a cycle that is itself waiting can expire, so a mem_ready arriving
  // on the final allowed cycle always wins over the timeout.
  assign expire = waiting && (count == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I main control FSM
//
// Purpose: sequences FETCH/DECODE/EXEC/MEM/WB over one shared memory port,
//          drives datapath enables/muxes, counts retired instructions and
//          holds sticky halt/illegal/mem_err terminal status.
// Ports:   clk, rst_n (sync active-low); opcode, mem_ready, branch_taken in;
//          mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src,
//          alu_op, mem_to_reg, reg_write, halt, illegal, mem_err, retired out.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 16,
  parameter bit EN_UPPER_IMM = 1'b1,
  parameter int RET_CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 mem_ready,
  input  logic                 branch_taken,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 alu_src,
  output logic [1:0]           alu_op,
  output logic [1:0]           mem_to_reg,
  output logic                 reg_write,
  output logic                 halt,
  output logic                 illegal,
  output logic                 mem_err,
  output logic [RET_CNT_W-1:0] retired
);

  state_e               state_q, state_d;
  logic [6:0]           op_q;
  logic [RET_CNT_W-1:0] retired_q;
  logic                 retire;
  logic                 expire;

  logic        req_c, we_c, iord_c, ir_write_c, pc_write_c, alu_src_c, reg_write_c;
  pc_src_e     pc_src_c;
  alu_op_e     alu_op_c;
  mem_to_reg_e m2r_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    req_c       = 1'b0;
    we_c        = 1'b0;
    iord_c      = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_src_c    = PC_PLUS4;
    alu_src_c   = 1'b0;
    alu_op_c    = ALU_ADD;
    m2r_c       = M2R_ALU;
    reg_write_c = 1'b0;

    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (expire) begin
          state_d = S_ERROR;
        end
      end
      // The IR is live here, so decode straight from opcode rather than op_q.
      S_DECODE: begin
        if (opcode == OP_HALT)                     state_d = S_HALTED;
        else if (!op_legal(opcode, EN_UPPER_IMM))  state_d = S_ILLEGAL;
        else                                       state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_R_TYPE: begin
            alu_op_c = ALU_R;
            state_d  = S_WB;
          end
          OP_I_TYPE: begin
            alu_src_c = 1'b1;
            alu_op_c  = ALU_I;
            state_d   = S_WB;
          end
          OP_LUI, OP_AUIPC: begin
            alu_src_c = 1'b1;
            state_d   = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_c = 1'b1;
            state_d   = S_MEM;
          end
          OP_BRANCH: begin
            alu_op_c   = ALU_BR;
            pc_write_c = branch_taken;
            pc_src_c   = PC_TARGET;
            retire     = 1'b1;
            state_d    = S_FETCH;
          end
          OP_JAL: begin
            reg_write_c = 1'b1;
            m2r_c       = M2R_PC4;
            pc_write_c  = 1'b1;
            pc_src_c    = PC_TARGET;
            retire      = 1'b1;
            state_d     = S_FETCH;
          end
          OP_JALR: begin
            alu_src_c   = 1'b1;
            alu_op_c    = ALU_I;
            reg_write_c = 1'b1;
            m2r_c       = M2R_PC4;
            pc_write_c  = 1'b1;
            pc_src_c    = PC_JALR;
            retire      = 1'b1;
            state_d     = S_FETCH;
          end
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_MEM: begin
        req_c  = 1'b1;
        iord_c = 1'b1;
        we_c   = (op_q == OP_SW);
        if (mem_ready) begin
          if (op_q == OP_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (expire) begin
          state_d = S_ERROR;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        if (op_q == OP_LW)       m2r_c = M2R_MEM;
        else if (op_q == OP_LUI) m2r_c = M2R_IMM;
        else                     m2r_c = M2R_ALU;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: ;  // terminal states hold with every enable low
    endcase
  end

  ctrl_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .waiting (req_c && !mem_ready),
    .clear   (mem_ready || (state_d != state_q)),
    .expire  (expire)
  );

  // Everything is gated by rst_n so an in-flight request drops the moment
  // reset is asserted, not one edge later.
  assign mem_req    = rst_n & req_c;
  assign mem_we     = rst_n & we_c;
  assign iord       = rst_n & iord_c;
  assign ir_write   = rst_n & ir_write_c;
  assign pc_write   = rst_n & pc_write_c;
  assign pc_src     = rst_n ? pc_src_c : 2'b00;
  assign alu_src    = rst_n & alu_src_c;
  assign alu_op     = rst_n ? alu_op_c : 2'b00;
  assign mem_to_reg = rst_n ? m2r_c : 2'b00;
  assign reg_write  = rst_n & reg_write_c;
  assign halt       = rst_n & (state_q == S_HALTED);
  assign illegal    = rst_n & (state_q == S_ILLEGAL);
  assign mem_err    = rst_n & (state_q == S_ERROR);
  assign retired    = rst_n ? retired_q : '0;

endmodule
